// File: rtl/branch_dispatch_ctrl.sv
// Dispatch-side controller: routes decoded instructions to the ALU, branch and
// load/store reservation stations, applies backpressure, serialises control
// flow around branches, and keeps performance counters and sticky error flags.
module branch_dispatch_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32,
    parameter int BR_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              dec_valid,
    input  logic [1:0]        dec_class,
    input  logic [ADDR_W-1:0] dec_pc,
    input  logic              alu_full,
    input  logic              branch_full,
    input  logic              ls_full,
    input  logic              br_done,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              dec_ready,
    output logic              alu_alloc_en,
    output logic              branch_alloc_en,
    output logic              ls_alloc_en,
    output logic              redirect_en,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  dispatch_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              err_timeout,
    output logic              err_spurious
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_WAIT  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_LS     = 2'd2,
        CLS_NOP    = 2'd3
    } dec_class_t;

    // Timeout counter is wide enough to hold BR_TIMEOUT itself so it can saturate there.
    localparam int TO_W = $clog2(BR_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(BR_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BR_TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic              target_full;
    logic              accept;
    logic              br_capture;
    logic              redirect_q;
    logic [ADDR_W-1:0] branch_pc;
    logic [TO_W-1:0]   to_cnt;

    // Decode-side handshake and zero-latency allocate pulses.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        target_full     = 1'b0;
        dec_ready       = 1'b0;
        accept          = 1'b0;
        alu_alloc_en    = 1'b0;
        branch_alloc_en = 1'b0;
        ls_alloc_en     = 1'b0;
        case (dec_class_t'(dec_class))
            CLS_ALU:    target_full = alu_full;
            CLS_BRANCH: target_full = branch_full;
            CLS_LS:     target_full = ls_full;
            default:    target_full = 1'b0;
        endcase
        dec_ready       = rdy && (state == RUN) && !target_full;
        accept          = dec_valid && dec_ready;
        alu_alloc_en    = accept && (dec_class == CLS_ALU);
        branch_alloc_en = accept && (dec_class == CLS_BRANCH);
        ls_alloc_en     = accept && (dec_class == CLS_LS);
    end

    assign br_capture  = rdy && br_done && (state == BR_WAIT);
    // The registered pulse is masked while the pipeline is globally stalled; state holds meanwhile.
    assign redirect_en = redirect_q && rdy;

    // Next-state logic: nothing advances while rdy is low.
    always_comb begin
        state_next = state;
        if (rdy) begin
            case (state)
                RUN:      if (branch_alloc_en) state_next = BR_WAIT;
                BR_WAIT:  if (br_done)         state_next = REDIRECT;
                REDIRECT:                      state_next = RUN;
                default:                       state_next = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // Branch PC capture, redirect generation, timeout tracking, counters and error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            redirect_q   <= 1'b0;
            redirect_pc  <= '0;
            branch_pc    <= '0;
            to_cnt       <= '0;
            dispatch_cnt <= '0;
            stall_cnt    <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else if (rdy) begin
            redirect_q <= br_capture;

            if (branch_alloc_en) branch_pc <= dec_pc;

            if (br_capture) begin
                redirect_pc <= br_taken ? br_target : branch_pc + ADDR_W'(4);
                to_cnt      <= '0;
            end else if (state == BR_WAIT && to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_LAST) err_timeout <= 1'b1;
            end

            if (br_done && state != BR_WAIT) err_spurious <= 1'b1;

            if (accept && dispatch_cnt != '1) dispatch_cnt <= dispatch_cnt + 1'b1;
            if (dec_valid && !dec_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
